// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: received byte, ready flag,
// stop-bit error pulse and the consumer's acknowledge.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frame_err;
  logic       clr_rdy;

  // Receiver drives the byte and status, consumer drives the acknowledge.
  modport master (
    output rx_data,
    output rdy,
    output frame_err,
    input  clr_rdy
  );

  modport slave (
    input  rx_data,
    input  rdy,
    input  frame_err,
    output clr_rdy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. The RX pin is double-synchronised, a falling
// edge in IDLE starts a frame, the start bit is re-checked at mid-bit, then
// eight data bits and the stop bit are sampled once per bit period at mid-bit.
// A good stop bit publishes the byte and raises rdy; a low stop bit gives a
// one-clock frame_err pulse and leaves the published byte alone.
module uart_rx #(
  parameter int BAUD_CYCLES = 2604,
  parameter int HALF_CYCLES = BAUD_CYCLES / 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     RX,
  uart_rx_if.master bus
);

  // Counter reload values, sized to the 12-bit baud counter.
  localparam logic [11:0] BAUD_LOAD = 12'(BAUD_CYCLES);
  localparam logic [11:0] HALF_LOAD = 12'(HALF_CYCLES);
  localparam logic [3:0]  LAST_DATA = 4'd8;
  localparam logic [3:0]  STOP_DONE = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // Synchroniser stages plus one more flop holding the previous synchronised
  // level, used only for falling-edge detection.
  logic        rx_ff1;
  logic        rx_ff2;
  logic        rx_prev;

  logic [11:0] baud_cnt_reg;
  logic [11:0] baud_cnt_next;
  logic [3:0]  bit_cnt_reg;
  logic [3:0]  bit_cnt_next;
  logic [7:0]  shift_reg;
  logic [7:0]  shift_next;
  logic [7:0]  rx_data_reg;
  logic [7:0]  rx_data_next;
  logic        rdy_reg;
  logic        rdy_next;
  logic        frame_err_reg;
  logic        frame_err_next;

  logic        start_edge;
  logic        baud_tick;

  // A start edge needs the line to have been seen high the cycle before, so
  // after a break or a bad stop bit the receiver re-arms only once RX rises.
  assign start_edge = (state_reg == IDLE) && rx_prev && !rx_ff2;

  // The sample point is the cycle in which the counter would reach zero; a
  // reload of N therefore spaces samples exactly N clocks apart.
  assign baud_tick = (baud_cnt_reg == 12'd1);

  // Two-flop synchroniser for the asynchronous RX pin, preset to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, counters, shifter and output flags.
  always_comb begin
    state_next     = state_reg;
    baud_cnt_next  = baud_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    rx_data_next   = rx_data_reg;
    rdy_next       = rdy_reg && !bus.clr_rdy;
    frame_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          baud_cnt_next = HALF_LOAD;
          state_next    = START;
          // A new frame invalidates the byte still on offer.
          rdy_next      = 1'b0;
        end
      end

      START: begin
        if (baud_tick) begin
          if (rx_ff2) begin
            // Line went back high before mid-start: treat as a glitch.
            baud_cnt_next = 12'd0;
            state_next    = IDLE;
          end else begin
            baud_cnt_next = BAUD_LOAD;
            bit_cnt_next  = 4'd0;
            state_next    = RECV;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg - 12'd1;
        end
      end

      RECV: begin
        if (baud_tick) begin
          if (bit_cnt_reg < LAST_DATA) begin
            // LSB arrives first, so shift right and insert at the MSB.
            shift_next    = {rx_ff2, shift_reg[7:1]};
            bit_cnt_next  = bit_cnt_reg + 4'd1;
            baud_cnt_next = BAUD_LOAD;
          end else begin
            // Stop-bit sample; leave at mid-stop so a back-to-back start
            // edge half a bit later is still caught.
            bit_cnt_next  = STOP_DONE;
            baud_cnt_next = 12'd0;
            state_next    = IDLE;
            if (rx_ff2) begin
              rx_data_next = shift_reg;
              // Completion overrides a simultaneous clr_rdy.
              rdy_next     = 1'b1;
            end else begin
              frame_err_next = 1'b1;
            end
          end
        end else begin
          baud_cnt_next = baud_cnt_reg - 12'd1;
        end
      end

      default: begin
        state_next    = IDLE;
        baud_cnt_next = 12'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_reg  <= 12'd0;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 8'h00;
      rx_data_reg   <= 8'h00;
      rdy_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      baud_cnt_reg  <= baud_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      rx_data_reg   <= rx_data_next;
      rdy_reg       <= rdy_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign bus.rx_data   = rx_data_reg;
  assign bus.rdy       = rdy_reg;
  assign bus.frame_err = frame_err_reg;

endmodule
